ps2_key: RTL and testbench



---
 rtl/ps2_key_if.sv | 10 +
 rtl/ps2_key.sv | 128 ++++++++++++
 tb/tb_ps2_key.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ps2_key_if.sv
// PS/2 receiver bus: raw keyboard pins in, decoded scan-code byte and strobe out.
interface ps2_key_if;
    logic       PS2_clk;
    logic       PS2_DAT;
    logic [7:0] data;
    logic       data_valid;

    modport master (output PS2_clk, output PS2_DAT, input data, input data_valid);
    modport slave  (input PS2_clk, input PS2_DAT, output data, output data_valid);
endinterface

// File: rtl/ps2_key.sv
// PS/2 keyboard receiver: 11-bit frames to 8-bit scan codes with a one-cycle strobe.
// Optional break-code filter via `define PS2KEY_BREAK_FILTER_EN.
module ps2_key #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    ps2_key_if.slave   ps2
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_n;
    logic [1:0]      clk_sync, dat_sync;
    logic            clk_prev;
    logic [2:0]      index, index_n;
    logic [7:0]      shift, shift_n;
    logic            parity, parity_n;
    logic [WD_W-1:0] wdog, wdog_n;
    logic [7:0]      data, data_n;
    logic            valid, valid_n;
`ifdef PS2KEY_BREAK_FILTER_EN
    logic            skip, skip_n;
`endif
    logic            fall_c, bit_c;

    assign fall_c = clk_prev & ~clk_sync[1];
    assign bit_c  = dat_sync[1];

    assign ps2.data       = data;
    assign ps2.data_valid = valid;

    // State register plus synchronisers and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
            state    <= IDLE;
            index    <= 3'd0;
            shift    <= 8'h00;
            parity   <= 1'b0;
            wdog     <= '0;
            data     <= 8'h00;
            valid    <= 1'b0;
`ifdef PS2KEY_BREAK_FILTER_EN
            skip     <= 1'b0;
`endif
        end else begin
            clk_sync <= {clk_sync[0], ps2.PS2_clk};
            dat_sync <= {dat_sync[0], ps2.PS2_DAT};
            clk_prev <= clk_sync[1];
            state    <= state_n;
            index    <= index_n;
            shift    <= shift_n;
            parity   <= parity_n;
            wdog     <= wdog_n;
            data     <= data_n;
            valid    <= valid_n;
`ifdef PS2KEY_BREAK_FILTER_EN
            skip     <= skip_n;
`endif
        end
    end

    // Next-state, watchdog and accept logic; a detected edge always beats timeout
    always_comb begin
        state_n  = state;
        index_n  = index;
        shift_n  = shift;
        parity_n = parity;
        wdog_n   = wdog;
        data_n   = data;
        valid_n  = 1'b0;
`ifdef PS2KEY_BREAK_FILTER_EN
        skip_n   = skip;
`endif
        if (fall_c) begin
            wdog_n = '0;
            unique case (state)
                IDLE: begin
                    if (!bit_c) begin
                        state_n = DATA;
                        index_n = 3'd0;
                    end
                end
                DATA: begin
                    shift_n[index] = bit_c;
                    index_n        = index + 3'd1;
                    if (index == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    parity_n = bit_c;
                    state_n  = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (bit_c && ((^shift) ^ parity)) begin
`ifdef PS2KEY_BREAK_FILTER_EN
                        // 0xF0 and the byte following it are swallowed
                        if (skip) begin
                            skip_n = 1'b0;
                        end else if (shift == 8'hF0) begin
                            skip_n = 1'b1;
                        end else begin
                            data_n  = shift;
                            valid_n = 1'b1;
                        end
`else
                        data_n  = shift;
                        valid_n = 1'b1;
`endif
                    end
                end
            endcase
        end else if (state != IDLE) begin
            if (wdog == WD_W'(TIMEOUT_CYCLES)) begin
                state_n = IDLE;
                wdog_n  = '0;
            end else begin
                wdog_n = wdog + WD_W'(1);
            end
        end else begin
            wdog_n = '0;
        end
    end
endmodule

// File: tb/tb_ps2_key.sv
// Randomised self-checking bench for ps2_key against a byte-level frame model.
module tb_ps2_key;
    localparam int unsigned TO = 300;
    localparam int unsigned H  = 10;   // half PS/2 bit period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_key_if ps2 ();

    ps2_key #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .ps2 (ps2.slave)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] mdata = 8'h00;
    bit         mskip = 1'b0;
    logic       prev_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: a frame is accepted iff parity is odd and stop is 1
    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) return;
`ifdef PS2KEY_BREAK_FILTER_EN
        if (mskip) begin
            mskip = 1'b0;
            return;
        end
        if (b == 8'hF0) begin
            mskip = 1'b1;
            return;
        end
`endif
        exp_q.push_back(b);
        mdata = b;
    endtask

    task automatic send_bit(input logic b);
        repeat (H / 2) @(posedge clk);
        ps2.PS2_DAT = b;
        repeat (H / 2) @(posedge clk);
        ps2.PS2_clk = 1'b0;
        repeat (H) @(posedge clk);
        ps2.PS2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits);
        logic [10:0] fr;
        fr[0]    = 1'b0;
        fr[8:1]  = b;
        fr[9]    = ~(^b) ^ bad_par;
        fr[10]   = ~bad_stop;
        for (int i = 0; i < nbits; i++) send_bit(fr[i]);
        ps2.PS2_DAT = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(b, bad_par, bad_stop, 11);
        model_frame(b, !bad_par && !bad_stop);
    endtask

    task automatic settle(input string tag, input int cycles);
        int n;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check($sformatf("%s_count", tag), 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        check($sformatf("%s_data", tag), 32'(ps2.data), 32'(mdata));
        got.delete();
        exp_q.delete();
    endtask

    // Capture every strobe; two strobes back to back is an error
    always @(negedge clk) begin
        if (ps2.data_valid) begin
            got.push_back(ps2.data);
            check("no_back_to_back", 32'(prev_v), 32'd0);
        end
        prev_v = ps2.data_valid;
    end

    initial begin
        logic [7:0] b;
        bit bp, bs;
        ps2.PS2_clk = 1'b1;
        ps2.PS2_DAT = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", 32'(ps2.data), 32'h00);
        check("reset_valid", 32'(ps2.data_valid), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        frame(8'h1C, 1'b0, 1'b0);
        settle("valid", 8);
        settle("valid_hold", 50);

        frame(8'h1C, 1'b1, 1'b0);
        settle("parity_err", 8);
        frame(8'h29, 1'b0, 1'b0);
        settle("after_parity", 8);

        frame(8'h1C, 1'b0, 1'b1);
        settle("stop_err", 8);

        // Partial frame then an immediate 0x29: merged bits decode as 0x2C with
        // bad parity, trailing bits start a new frame that later times out.
        frame(8'h1C, 1'b0, 1'b0);
        settle("pre_nowait", 8);
        send_bits(8'h1C, 1'b0, 1'b0, 5);
        send_bits(8'h29, 1'b0, 1'b0, 11);
        settle("nowait", TO + 50);
        @(negedge clk);
        check("nowait_not_29", 32'(ps2.data == 8'h29), 32'd0);

        send_bits(8'h1C, 1'b0, 1'b0, 5);
        repeat (TO + 50) @(posedge clk);
        frame(8'h29, 1'b0, 1'b0);
        settle("timeout_recover", 8);

        send_bits(8'h1C, 1'b0, 1'b0, 7);
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_data", 32'(ps2.data), 32'h00);
        check("midreset_valid", 32'(ps2.data_valid), 32'd0);
        mdata = 8'h00;
        mskip = 1'b0;
        exp_q.delete();
        got.delete();
        frame(8'h32, 1'b0, 1'b0);
        settle("after_reset", 8);

        frame(8'h1C, 1'b0, 1'b0);
        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h1C, 1'b0, 1'b0);
        frame(8'h1B, 1'b0, 1'b0);
        settle("break_seq", 8);

        frame(8'h29, 1'b0, 1'b0);
        settle("pre_glitch", 8);
        send_bit(1'b1);
        settle("glitch", 20);
        frame(8'h1C, 1'b0, 1'b0);
        settle("after_glitch", 8);

        for (int k = 0; k < 24; k++) begin
            b  = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
            bp = ($urandom_range(0, 4) == 0);
            bs = ($urandom_range(0, 7) == 0);
            frame(b, bp, bs);
            repeat ($urandom_range(0, 30)) @(posedge clk);
            if (k % 6 == 5) settle($sformatf("rand%0d", k), 8);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
